// File: rtl/wb_host_bridge.sv
// rtl/wb_host_bridge.sv - Wishbone classic single-transfer initiator
// with a valid/ready command port and a valid/ready response port.
module wb_host_bridge #(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rstn_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [ADR_W-1:0]   cmd_adr_i,
    input  logic [DAT_W-1:0]   cmd_dat_i,
    input  logic [DAT_W/8-1:0] cmd_sel_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DAT_W-1:0]   rsp_dat_o,
    output logic               rsp_err_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [DAT_W/8-1:0] wbm_sel_o,
    output logic [ADR_W-1:0]   wbm_adr_o,
    output logic [DAT_W-1:0]   wbm_dat_o,
    input  logic               wbm_ack_i,
    input  logic [DAT_W-1:0]   wbm_dat_i
);
    localparam int SEL_W = DAT_W / 8;
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

    state_t             state_q, state_d;
    logic               cyc_q, cyc_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_q, dat_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_hit;

    // Counter holds the number of completed BUS cycles, so TO_LAST ends the strobe after TIMEOUT cycles.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    dat_d   = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (timeout_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = stb_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
endmodule

// File: doc/wb_host_bridge.md
Name: wb_host_bridge

Overview:
- Wishbone classic single-transfer initiator: the host end of the user area's Wishbone slave port (WB MI A).
- Accepts one command at a time on a valid/ready command port and drives one Wishbone cycle to the slave.
- Returns read data or a timeout error on a valid/ready response port.
- Used as a bench and bring-up master for user projects: test harnesses and LA-driven access paths instantiate it on the user side of the wrapper.

Parameters:
- ADR_W, 32, Wishbone address width.
- DAT_W, 32, Wishbone data width; SEL width = DAT_W/8.
- TIMEOUT, 255, BUS-state cycles without ack before abort; 0 disables the timeout.

Ports:
- wb_clk_i  in  1  single clock, all logic rising-edge.
- wb_rstn_i  in  1  reset, asynchronous assert, active-low (already decided; synchronous deassert handled upstream).
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  bridge can accept a command.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADR_W  byte address.
- cmd_dat_i  in  DAT_W  write data.
- cmd_sel_i  in  DAT_W/8  byte enables.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_dat_o  out  DAT_W  read data; 0 for writes and errors.
- rsp_err_o  out  1  1 = timeout abort.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  DAT_W/8  Wishbone byte select.
- wbm_adr_o  out  ADR_W  Wishbone address.
- wbm_dat_o  out  DAT_W  Wishbone write data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_dat_i  in  DAT_W  Wishbone read data.

Behaviour:
- All outputs are registered except cmd_ready_o, which decodes state (1 iff IDLE).
- Reset values: state IDLE; cyc/stb/we = 0; sel/adr/dat = 0; rsp_valid = 0; rsp_dat = 0; rsp_err = 0; timeout counter = 0. cmd_ready_o = 1 while in reset and after it.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - On cmd_valid_i & cmd_ready_o, latch we/adr/dat/sel into the wbm_* registers and set cyc = stb = 1.
  - Clear the counter and go to BUS.
  - The first strobe cycle is the cycle after acceptance.
- BUS:
  - cyc, stb, we, sel, adr and dat are held stable. cmd_ready_o = 0.
  - The counter increments each BUS cycle; width is clog2(TIMEOUT+1), saturating.
  - On wbm_ack_i = 1 (sampled at the edge): clear cyc/stb; set rsp_dat = wbm_dat_i for reads, 0 for writes; set rsp_err = 0 and rsp_valid = 1; go to RESP.
  - Timeout: if TIMEOUT != 0, ack = 0 and the counter equals TIMEOUT-1 at the edge, clear cyc/stb, set rsp_err = 1, rsp_dat = 0, rsp_valid = 1, and go to RESP.
  - The strobe is therefore high for exactly TIMEOUT cycles.
  - Ack and timeout in the same cycle: ack wins, rsp_err = 0.
- RESP:
  - rsp_* held stable. cmd_ready_o = 0.
  - On rsp_ready_i = 1, clear rsp_valid and go to IDLE; the next command can be accepted the following cycle.
- Latency: command accepted at edge N → stb high during cycle N+1. With a zero-wait slave (ack during N+1), rsp_valid is high during cycle N+2. Minimum command-to-command spacing is 3 cycles.
- wbm_ack_i in IDLE or RESP is ignored and has no effect on any state.
- cmd_* changes while not accepted are ignored. wbm_* outputs keep their last address/data in IDLE; only cyc/stb carry meaning.
- Reset asserted mid-operation: cyc/stb fall asynchronously, any pending response is discarded with no rsp_valid, and the FSM returns to IDLE.

Test Plan:
- Zero-wait write: cmd we=1, adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF; slave acks in the first stb cycle → cyc/stb high for exactly 1 cycle with those values; rsp_valid one cycle later with rsp_err=0, rsp_dat=0.
- Wait-state read: we=0, adr=0x3000_0010; slave acks after 5 stb cycles with dat=0xDEAD_BEEF → stb high 5 cycles, adr stable throughout, rsp_dat=0xDEAD_BEEF, rsp_err=0.
- Timeout: TIMEOUT=8, slave never acks → stb high exactly 8 cycles, then rsp_err=1, rsp_dat=0; the next command is accepted normally afterwards.
- Ack coincident with timeout: TIMEOUT=8, ack in the 8th stb cycle with dat=0x1 → rsp_err=0, rsp_dat=0x1.
- Backpressure and spurious ack: hold rsp_ready=0 for 10 cycles and pulse wbm_ack_i during RESP and during IDLE → rsp fields stable, cmd_ready=0 until rsp_ready, no extra cycle issued, no state change.
- Reset mid-BUS: deassert wb_rstn_i in the 3rd stb cycle → cyc/stb drop without waiting for a clock edge, rsp_valid stays 0, cmd_ready=1; a fresh read then completes correctly.
